// File: rtl/host_mem_ctl.sv
// Host access controller: decodes SPI command/data bytes into CPU reset control,
// channel select, address load and auto-incrementing byte writes/reads. Optional checksum: HOST_CSUM_EN.
module host_mem_ctl #(
    parameter int XLEN = 32,
    parameter int AW   = 32,
    parameter int CH   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dc_i,
    input  logic                 byte_vld_i,
    input  logic [7:0]           byte_data_i,
    output logic [7:0]           rd_byte_o,
    output logic                 cpu_rst_n_o,
    output logic [CH-1:0]        ch_sel_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic                 mem_rd_en_o,
    input  logic [CH*XLEN-1:0]   mem_rd_data_i,
    output logic                 mem_wr_en_o,
    output logic [XLEN/8-1:0]    mem_wr_byte_en_o,
    output logic [XLEN-1:0]      mem_wr_data_o,
    output logic                 err_o
);
    localparam int LANES = XLEN / 8;
    localparam int LW    = $clog2(LANES);
    localparam int NB    = AW / 8;
    localparam int CW    = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [7:0] CMD_RST   = 8'h2A;
    localparam logic [7:0] CMD_RUN   = 8'h2B;
    localparam logic [7:0] CMD_ADDR  = 8'h2C;
    localparam logic [7:0] CMD_WRITE = 8'h2D;
    localparam logic [7:0] CMD_READ  = 8'h2E;
    localparam logic [7:0] CMD_CHSEL = 8'h2F;
`ifdef HOST_CSUM_EN
    localparam logic [7:0] CMD_CSUM  = 8'h30;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_CHSEL
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [AW-1:0]     shadow_reg, shadow_next;
    logic [AW-1:0]     addr_reg, addr_next, addr_base;
    logic              cpu_rst_n_reg, cpu_rst_n_next;
    logic [CH-1:0]     ch_sel_reg, ch_sel_next;
    logic [7:0]        rd_byte_reg, rd_byte_next;
    logic              rd_en_reg, rd_en_next;
    logic              wr_en_reg, wr_en_next;
    logic [LANES-1:0]  wr_be_reg, wr_be_next;
    logic [XLEN-1:0]   wr_data_reg, wr_data_next;
    logic              err_reg, err_next;
    logic              rd_cap_reg;
    logic [LW-1:0]     rd_lane_reg;
    logic [CH-1:0]     rd_ch_reg;
`ifdef HOST_CSUM_EN
    logic [7:0]        csum_reg, csum_next;
`endif

    // Split the flat read bus into per-channel words and the chosen word into lanes.
    logic [XLEN-1:0] ch_word [CH];
    logic [XLEN-1:0] sel_word;
    logic [7:0]      sel_lane [LANES];

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        assign ch_word[gi] = mem_rd_data_i[gi*XLEN +: XLEN];
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign sel_lane[gi] = sel_word[gi*8 +: 8];
    end

    always_comb begin
        sel_word = '0;
        for (int c = 0; c < CH; c++) begin
            if (rd_ch_reg[c]) sel_word = sel_word | ch_word[c];
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shadow_next    = shadow_reg;
        cpu_rst_n_next = cpu_rst_n_reg;
        ch_sel_next    = ch_sel_reg;
        rd_byte_next   = rd_byte_reg;
        rd_en_next     = 1'b0;
        wr_en_next     = 1'b0;
        wr_be_next     = wr_be_reg;
        wr_data_next   = wr_data_reg;
        err_next       = 1'b0;
`ifdef HOST_CSUM_EN
        csum_next      = csum_reg;
`endif
        // A write strobe in flight bumps the address at this edge; new bytes see that value.
        addr_base      = addr_reg + AW'(wr_en_reg);
        addr_next      = addr_base;

        if (rd_cap_reg) rd_byte_next = sel_lane[rd_lane_reg];

        if (byte_vld_i && dc_i) begin
            cnt_next   = '0;
            state_next = S_IDLE;
            case (byte_data_i)
                CMD_RST:   cpu_rst_n_next = 1'b0;
                CMD_RUN:   cpu_rst_n_next = 1'b1;
                CMD_ADDR:  state_next = S_ADDR;
                CMD_WRITE: begin
                    state_next = S_WRITE;
`ifdef HOST_CSUM_EN
                    csum_next  = 8'h00;
`endif
                end
                CMD_READ: begin
                    state_next = S_READ;
                    rd_en_next = 1'b1;
                end
                CMD_CHSEL: state_next = S_CHSEL;
`ifdef HOST_CSUM_EN
                CMD_CSUM:  rd_byte_next = csum_reg;
`endif
                default:   err_next = 1'b1;
            endcase
        end else if (byte_vld_i) begin
            case (state_reg)
                S_ADDR: begin
                    shadow_next[8*int'(cnt_reg) +: 8] = byte_data_i;
                    if (cnt_reg == CW'(NB - 1)) begin
                        addr_next  = shadow_next;
                        cnt_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                S_CHSEL: begin
                    if (int'(byte_data_i) < CH) begin
                        for (int c = 0; c < CH; c++) ch_sel_next[c] = (int'(byte_data_i) == c);
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = S_IDLE;
                end
                S_WRITE: begin
                    wr_en_next                   = 1'b1;
                    wr_be_next                   = '0;
                    wr_be_next[addr_base[LW-1:0]] = 1'b1;
                    wr_data_next                 = {LANES{byte_data_i}};
`ifdef HOST_CSUM_EN
                    csum_next                    = csum_reg + byte_data_i;
`endif
                end
                S_READ: begin
                    addr_next  = addr_base + AW'(1);
                    rd_en_next = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            shadow_reg    <= '0;
            addr_reg      <= '0;
            cpu_rst_n_reg <= 1'b0;
            ch_sel_reg    <= CH'(1);
            rd_byte_reg   <= '0;
            rd_en_reg     <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_be_reg     <= '0;
            wr_data_reg   <= '0;
            err_reg       <= 1'b0;
            rd_cap_reg    <= 1'b0;
            rd_lane_reg   <= '0;
            rd_ch_reg     <= CH'(1);
`ifdef HOST_CSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shadow_reg    <= shadow_next;
            addr_reg      <= addr_next;
            cpu_rst_n_reg <= cpu_rst_n_next;
            ch_sel_reg    <= ch_sel_next;
            rd_byte_reg   <= rd_byte_next;
            rd_en_reg     <= rd_en_next;
            wr_en_reg     <= wr_en_next;
            wr_be_reg     <= wr_be_next;
            wr_data_reg   <= wr_data_next;
            err_reg       <= err_next;
            // Remember where the read pulse pointed; the address may move before data returns.
            rd_cap_reg    <= rd_en_reg;
            rd_lane_reg   <= addr_reg[LW-1:0];
            rd_ch_reg     <= ch_sel_reg;
`ifdef HOST_CSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    assign rd_byte_o        = rd_byte_reg;
    assign cpu_rst_n_o      = cpu_rst_n_reg;
    assign ch_sel_o         = ch_sel_reg;
    assign mem_addr_o       = addr_reg;
    assign mem_rd_en_o      = rd_en_reg;
    assign mem_wr_en_o      = wr_en_reg;
    assign mem_wr_byte_en_o = wr_be_reg;
    assign mem_wr_data_o    = wr_data_reg;
    assign err_o            = err_reg;

endmodule

// File: tb/tb_host_mem_ctl.sv
// Scoreboard bench for host_mem_ctl: expected write strobes and read bytes are queued
// as bytes are sent and compared when the DUT produces them.
module tb_host_mem_ctl;
    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int CH   = 2;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                dc_i = 1'b0;
    logic                byte_vld_i = 1'b0;
    logic [7:0]          byte_data_i = 8'h00;
    logic [7:0]          rd_byte_o;
    logic                cpu_rst_n_o;
    logic [CH-1:0]       ch_sel_o;
    logic [AW-1:0]       mem_addr_o;
    logic                mem_rd_en_o;
    logic [CH*XLEN-1:0]  mem_rd_data_i = '0;
    logic                mem_wr_en_o;
    logic [XLEN/8-1:0]   mem_wr_byte_en_o;
    logic [XLEN-1:0]     mem_wr_data_o;
    logic                err_o;

    host_mem_ctl #(.XLEN(XLEN), .AW(AW), .CH(CH)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .dc_i             (dc_i),
        .byte_vld_i       (byte_vld_i),
        .byte_data_i      (byte_data_i),
        .rd_byte_o        (rd_byte_o),
        .cpu_rst_n_o      (cpu_rst_n_o),
        .ch_sel_o         (ch_sel_o),
        .mem_addr_o       (mem_addr_o),
        .mem_rd_en_o      (mem_rd_en_o),
        .mem_rd_data_i    (mem_rd_data_i),
        .mem_wr_en_o      (mem_wr_en_o),
        .mem_wr_byte_en_o (mem_wr_byte_en_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [7:0]  rd_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_cnt  = 0;
    int          wr_cnt   = 0;
    logic [31:0] cur_addr = 32'h0;
    logic [1:0]  cur_ch   = 2'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] word_of(input int c, input logic [29:0] widx);
        if (c == 1 && widx == 30'd2) return 32'h44332211;
        return {8'(c + 1), widx[7:0], 8'hC3, 8'h3C};
    endfunction

    // Memory model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en_o) begin
            for (int c = 0; c < CH; c++)
                mem_rd_data_i[c*XLEN +: XLEN] <= word_of(c, mem_addr_o[31:2]);
        end
    end

    // Write strobe and error monitor.
    always @(negedge clk) begin
        if (err_o) err_cnt++;
        if (mem_wr_en_o) begin
            wr_t e;
            wr_cnt++;
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                $display("write addr=%08h be=%b data=%08h", mem_addr_o, mem_wr_byte_en_o, mem_wr_data_o);
                check("wr_addr", 64'(mem_addr_o), 64'(e.addr));
                check("wr_be",   64'(mem_wr_byte_en_o), 64'(e.be));
                check("wr_data", 64'(mem_wr_data_o), 64'(e.data));
            end
        end
    end

    // Read monitor: rd_byte_o is compared two cycles after each read pulse.
    logic rd_d1 = 1'b0, rd_d2 = 1'b0;
    always @(negedge clk) begin
        if (rst_i) begin
            rd_d1 = 1'b0;
            rd_d2 = 1'b0;
        end else begin
            if (rd_d2) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 64'(rd_byte_o), 64'h1FF);
                end else begin
                    logic [7:0] eb;
                    eb = rd_q.pop_front();
                    $display("read byte=%02h", rd_byte_o);
                    check("rd_byte", 64'(rd_byte_o), 64'(eb));
                end
            end
            rd_d2 = rd_d1;
            rd_d1 = mem_rd_en_o;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        dc_i        = dc;
        byte_data_i = b;
        byte_vld_i  = 1'b1;
        @(posedge clk);
        #1;
        byte_vld_i  = 1'b0;
    endtask

    task automatic send_wr(input logic [7:0] b);
        wr_t e;
        e.addr = cur_addr;
        e.be   = 4'b0001 << cur_addr[1:0];
        e.data = {4{b}};
        wr_q.push_back(e);
        cur_addr = cur_addr + 32'd1;
        send(1'b0, b);
    endtask

    function automatic logic [7:0] rd_exp(input logic [31:0] a);
        logic [31:0] w;
        w = word_of(int'(cur_ch), a[31:2]);
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic send_addr(input logic [31:0] a);
        send(1'b1, 8'h2C);
        for (int i = 0; i < 4; i++) send(1'b0, a[8*i +: 8]);
        cur_addr = a;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int w0;
        idle(3);
        #1;
        rst_i = 1'b0;
        idle(2);

        // 1. Reset and RUN
        check("rst_cpu_rst_n", 64'(cpu_rst_n_o), 64'd0);
        check("rst_ch_sel",    64'(ch_sel_o), 64'd1);
        check("rst_addr",      64'(mem_addr_o), 64'd0);
        check("rst_rd_byte",   64'(rd_byte_o), 64'd0);
        send(1'b1, 8'h2B);
        check("run_cpu_rst_n", 64'(cpu_rst_n_o), 64'd1);

        // 2. Addressed back-to-back write
        send_addr(32'h0000_1003);
        check("addr_load", 64'(mem_addr_o), 64'h1003);
        send(1'b1, 8'h2D);
        send_wr(8'hA5);
        send_wr(8'h5A);
        idle(3);
        check("wr_final_addr", 64'(mem_addr_o), 64'h1005);

        // 3. Channel select and read
        send(1'b1, 8'h2F);
        send(1'b0, 8'h01);
        cur_ch = 2'd1;
        check("chsel_1", 64'(ch_sel_o), 64'd2);
        send_addr(32'h0000_0008);
        rd_q.push_back(rd_exp(cur_addr));
        send(1'b1, 8'h2E);
        idle(2);
        check("rd_latency", 64'(rd_byte_o), 64'h11);
        cur_addr = cur_addr + 32'd1;
        rd_q.push_back(rd_exp(cur_addr));
        send(1'b0, 8'h00);
        idle(2);
        check("rd_dummy", 64'(rd_byte_o), 64'h22);
        check("rd_addr_inc", 64'(mem_addr_o), 64'h9);

        // 4. Errors
        e0 = err_cnt;
        send(1'b1, 8'h77);
        idle(2);
        check("err_unknown_cmd", 64'(err_cnt - e0), 64'd1);
        send(1'b0, 8'h42);
        e0 = err_cnt;
        send(1'b1, 8'h2F);
        send(1'b0, 8'h05);
        idle(2);
        check("err_chsel_range", 64'(err_cnt - e0), 64'd1);
        check("chsel_kept", 64'(ch_sel_o), 64'd2);

        // 5. Abort, wrap, reset mid-transfer
        send(1'b1, 8'h2C);
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b1, 8'h2D);
        idle(1);
        check("abort_addr", 64'(mem_addr_o), 64'h9);
        send_addr(32'hFFFF_FFFF);
        send(1'b1, 8'h2D);
        send_wr(8'h3C);
        idle(3);
        check("wrap_addr", 64'(mem_addr_o), 64'h0);
        send_addr(32'h0000_0055);
        send(1'b1, 8'h2D);
        w0 = wr_cnt;
        rst_i       = 1'b1;
        dc_i        = 1'b0;
        byte_data_i = 8'h99;
        byte_vld_i  = 1'b1;
        @(posedge clk);
        #1;
        byte_vld_i  = 1'b0;
        rst_i       = 1'b0;
        idle(3);
        check("rst_no_strobe",  64'(wr_cnt - w0), 64'd0);
        check("rst2_cpu_rst_n", 64'(cpu_rst_n_o), 64'd0);
        check("rst2_ch_sel",    64'(ch_sel_o), 64'd1);
        check("rst2_addr",      64'(mem_addr_o), 64'd0);
        check("rst2_rd_byte",   64'(rd_byte_o), 64'd0);
        cur_ch = 2'd0;

        // 6. Checksum command
`ifdef HOST_CSUM_EN
        send(1'b1, 8'h2D);
        cur_addr = 32'h0;
        send_wr(8'h80);
        send_wr(8'h90);
        send(1'b1, 8'h30);
        check("csum", 64'(rd_byte_o), 64'h10);
`else
        e0 = err_cnt;
        send(1'b1, 8'h30);
        idle(2);
        check("csum_cmd_unknown", 64'(err_cnt - e0), 64'd1);
`endif

        idle(5);
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
